// File: rtl/cs_address_sequencer_pkg.sv
// Shared definitions for the microprogram address sequencer: select codes,
// FSM state encoding, default trap microaddress and select classification.
package cs_address_sequencer_pkg;

    localparam int ADDRWIDTH_CS_DEF = 11;
    localparam int OPWIDTH_IR_DEF   = 8;

    localparam logic [1:0] SEL_NEXT    = 2'b00;
    localparam logic [1:0] SEL_JUMP    = 2'b01;
    localparam logic [1:0] SEL_DECODE  = 2'b10;
    localparam logic [1:0] SEL_ILLEGAL = 2'b11;

    localparam logic [ADDRWIDTH_CS_DEF-1:0] TRAP_ADDR_DEF = 11'h7FC;

    typedef enum logic [1:0] {
        S_INIT = 2'b00,
        S_RUN  = 2'b01,
        S_HOLD = 2'b10,
        S_TRAP = 2'b11
    } cs_state_e;

    // Anything that is not a legal select (including X in simulation) traps.
    function automatic logic sel_is_illegal(input logic [1:0] sel);
        logic ill;
        case (sel)
            SEL_NEXT, SEL_JUMP, SEL_DECODE: ill = 1'b0;
            default:                        ill = 1'b1;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/cs_addr_mux.sv
// Combinational candidate next-address selection: increment, jump target,
// opcode decode dispatch, or trap vector.
module cs_addr_mux
    import cs_address_sequencer_pkg::*;
#(
    parameter int                      ADDRWIDTH_CS = ADDRWIDTH_CS_DEF,
    parameter int                      OPWIDTH_IR   = OPWIDTH_IR_DEF,
    parameter logic [ADDRWIDTH_CS-1:0] TRAP_ADDR    = ADDRWIDTH_CS'(TRAP_ADDR_DEF)
) (
    input  logic [1:0]              sel_i,
    input  logic [ADDRWIDTH_CS-1:0] csai_i,
    input  logic [ADDRWIDTH_CS-1:0] jump_i,
    input  logic [OPWIDTH_IR-1:0]   op_i,
    output logic [ADDRWIDTH_CS-1:0] cand_o
);

    localparam int DEC_W = OPWIDTH_IR + 3;

    // Dispatch table lives in the upper half of the control store, 4 words per opcode.
    logic [DEC_W-1:0] dec_addr;
    assign dec_addr = {1'b1, op_i, 2'b00};

    always_comb begin
        cand_o = TRAP_ADDR;
        case (sel_i)
            SEL_NEXT:   cand_o = csai_i + ADDRWIDTH_CS'(1);
            SEL_JUMP:   cand_o = jump_i;
            SEL_DECODE: cand_o = ADDRWIDTH_CS'(dec_addr);
            default:    cand_o = TRAP_ADDR;
        endcase
    end

endmodule

// File: rtl/cs_address_sequencer.sv
// Microprogram address sequencer: registered control-store address with
// init/run/stall-hold/sticky-trap control.
module cs_address_sequencer
    import cs_address_sequencer_pkg::*;
#(
    parameter int                      ADDRWIDTH_CS = ADDRWIDTH_CS_DEF,
    parameter int                      OPWIDTH_IR   = OPWIDTH_IR_DEF,
    parameter logic [ADDRWIDTH_CS-1:0] TRAP_ADDR    = ADDRWIDTH_CS'(TRAP_ADDR_DEF)
) (
    input  logic                    CLK,
    input  logic                    RESET_InLow,
    input  logic [1:0]              Control_Branch_In,
    input  logic [ADDRWIDTH_CS-1:0] JumpAddr_In,
    input  logic [OPWIDTH_IR-1:0]   IR_Op_In,
    input  logic                    Stall_In,
    input  logic                    TrapClear_In,
    output logic [ADDRWIDTH_CS-1:0] CSAI_Out,
    output logic                    Valid_Out,
    output logic                    Trap_Out
);

    cs_state_e               state_q, state_d;
    logic [ADDRWIDTH_CS-1:0] csai_q, csai_d;
    logic                    trap_q, trap_d;
    logic [ADDRWIDTH_CS-1:0] cand;

    cs_addr_mux #(
        .ADDRWIDTH_CS (ADDRWIDTH_CS),
        .OPWIDTH_IR   (OPWIDTH_IR),
        .TRAP_ADDR    (TRAP_ADDR)
    ) u_mux (
        .sel_i  (Control_Branch_In),
        .csai_i (csai_q),
        .jump_i (JumpAddr_In),
        .op_i   (IR_Op_In),
        .cand_o (cand)
    );

    always_ff @(posedge CLK or negedge RESET_InLow) begin
        if (!RESET_InLow) begin
            state_q <= S_INIT;
            csai_q  <= '0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            csai_q  <= csai_d;
            trap_q  <= trap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        csai_d  = csai_q;
        trap_d  = trap_q;
        case (state_q)
            S_INIT: begin
                state_d = S_RUN;
                csai_d  = '0;
            end
            S_RUN: begin
                // A stall wins over everything; the select is looked at again after release.
                if (Stall_In) begin
                    state_d = S_HOLD;
                end else if (sel_is_illegal(Control_Branch_In)) begin
                    state_d = S_TRAP;
                    csai_d  = TRAP_ADDR;
                    trap_d  = 1'b1;
                end else begin
                    csai_d  = cand;
                end
            end
            S_HOLD: begin
                if (!Stall_In) state_d = S_RUN;
            end
            S_TRAP: begin
                csai_d = TRAP_ADDR;
                trap_d = 1'b1;
                if (TrapClear_In) begin
                    state_d = S_INIT;
                    csai_d  = '0;
                    trap_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_INIT;
                csai_d  = '0;
                trap_d  = 1'b0;
            end
        endcase
    end

    assign CSAI_Out  = csai_q;
    assign Valid_Out = (state_q == S_RUN) || (state_q == S_TRAP);
    assign Trap_Out  = trap_q;

endmodule

// File: tb/tb_cs_address_sequencer.sv
// Scoreboard bench for cs_address_sequencer: directed stimulus pushes expected
// outputs, a separate monitor pops and compares them.
module tb_cs_address_sequencer;

    logic        CLK;
    logic        RESET_InLow;
    logic [1:0]  Control_Branch_In;
    logic [10:0] JumpAddr_In;
    logic [7:0]  IR_Op_In;
    logic        Stall_In;
    logic        TrapClear_In;
    logic [10:0] CSAI_Out;
    logic        Valid_Out;
    logic        Trap_Out;

    cs_address_sequencer dut (
        .CLK               (CLK),
        .RESET_InLow       (RESET_InLow),
        .Control_Branch_In (Control_Branch_In),
        .JumpAddr_In       (JumpAddr_In),
        .IR_Op_In          (IR_Op_In),
        .Stall_In          (Stall_In),
        .TrapClear_In      (TrapClear_In),
        .CSAI_Out          (CSAI_Out),
        .Valid_Out         (Valid_Out),
        .Trap_Out          (Trap_Out)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [10:0] addr;
        logic        vld;
        logic        trp;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    event chk_ev;

    // Monitor: checks every pending expectation at each falling edge, or at once on request.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK or chk_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_chk++;
                if (CSAI_Out !== e.addr || Valid_Out !== e.vld || Trap_Out !== e.trp) begin
                    n_fail++;
                    $display("FAIL %s: got csai=%h valid=%b trap=%b, expected csai=%h valid=%b trap=%b",
                             e.name, CSAI_Out, Valid_Out, Trap_Out, e.addr, e.vld, e.trp);
                end
            end
        end
    end

    task automatic push(input logic [10:0] a, input logic v, input logic t, input string nm);
        exp_t e;
        e.addr = a; e.vld = v; e.trp = t; e.name = nm;
        exp_q.push_back(e);
    endtask

    // Apply inputs, take one rising edge, record what the outputs must then be.
    task automatic step(input logic [1:0] sel, input logic [10:0] jmp, input logic [7:0] op,
                        input logic stall, input logic clr,
                        input logic [10:0] ea, input logic ev, input logic et, input string nm);
        Control_Branch_In = sel;
        JumpAddr_In       = jmp;
        IR_Op_In          = op;
        Stall_In          = stall;
        TrapClear_In      = clr;
        @(posedge CLK);
        push(ea, ev, et, nm);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_InLow       = 1'b0;
        Control_Branch_In = 2'b00;
        JumpAddr_In       = '0;
        IR_Op_In          = '0;
        Stall_In          = 1'b0;
        TrapClear_In      = 1'b0;
        #3;
        push(11'h000, 1'b0, 1'b0, "reset_state");
        -> chk_ev;
        #9 RESET_InLow = 1'b1;

        // Init cycle then sequential advance
        step(2'b00, 11'h000, 8'h00, 1'b0, 1'b0, 11'h000, 1'b1, 1'b0, "init_to_run");
        step(2'b00, 11'h000, 8'h00, 1'b0, 1'b0, 11'h001, 1'b1, 1'b0, "next_1");
        step(2'b00, 11'h000, 8'h00, 1'b0, 1'b0, 11'h002, 1'b1, 1'b0, "next_2");
        step(2'b00, 11'h000, 8'h00, 1'b0, 1'b0, 11'h003, 1'b1, 1'b0, "next_3");
        step(2'b00, 11'h000, 8'h00, 1'b0, 1'b0, 11'h004, 1'b1, 1'b0, "next_4");

        // Wrap at the top of the control store
        step(2'b01, 11'h7FF, 8'h00, 1'b0, 1'b0, 11'h7FF, 1'b1, 1'b0, "jump_7ff");
        step(2'b00, 11'h000, 8'h00, 1'b0, 1'b0, 11'h000, 1'b1, 1'b0, "wrap_to_0");

        // Jump and decode dispatch
        step(2'b01, 11'h123, 8'h00, 1'b0, 1'b0, 11'h123, 1'b1, 1'b0, "jump_123");
        step(2'b10, 11'h000, 8'h81, 1'b0, 1'b0, 11'h604, 1'b1, 1'b0, "decode_81");

        // Stall holds, release edge does not advance
        step(2'b01, 11'h0AA, 8'h00, 1'b1, 1'b0, 11'h604, 1'b0, 1'b0, "stall_1");
        step(2'b01, 11'h0AA, 8'h00, 1'b1, 1'b0, 11'h604, 1'b0, 1'b0, "stall_2");
        step(2'b01, 11'h0AA, 8'h00, 1'b1, 1'b0, 11'h604, 1'b0, 1'b0, "stall_3");
        step(2'b01, 11'h0AA, 8'h00, 1'b0, 1'b0, 11'h604, 1'b1, 1'b0, "stall_release");
        step(2'b01, 11'h0AA, 8'h00, 1'b0, 1'b0, 11'h0AA, 1'b1, 1'b0, "jump_after_stall");

        // Stall beats illegal select; trap taken after release
        step(2'b11, 11'h000, 8'h00, 1'b1, 1'b0, 11'h0AA, 1'b0, 1'b0, "stall_beats_trap");
        step(2'b11, 11'h000, 8'h00, 1'b0, 1'b0, 11'h0AA, 1'b1, 1'b0, "release_no_trap");
        step(2'b11, 11'h000, 8'h00, 1'b0, 1'b0, 11'h7FC, 1'b1, 1'b1, "trap_entry");
        step(2'b01, 11'h123, 8'h00, 1'b1, 1'b0, 11'h7FC, 1'b1, 1'b1, "trap_sticky_1");
        step(2'b10, 11'h000, 8'h81, 1'b0, 1'b0, 11'h7FC, 1'b1, 1'b1, "trap_sticky_2");
        step(2'b00, 11'h000, 8'h00, 1'b1, 1'b1, 11'h000, 1'b0, 1'b0, "trap_clear");
        step(2'b00, 11'h000, 8'h00, 1'b0, 1'b0, 11'h000, 1'b1, 1'b0, "clear_init_to_run");
        step(2'b00, 11'h000, 8'h00, 1'b0, 1'b0, 11'h001, 1'b1, 1'b0, "clear_next_1");
        step(2'b00, 11'h000, 8'h00, 1'b0, 1'b1, 11'h002, 1'b1, 1'b0, "clear_ignored_in_run");

        // Async reset between edges while a jump is pending
        step(2'b01, 11'h3C3, 8'h00, 1'b0, 1'b0, 11'h3C3, 1'b1, 1'b0, "jump_3c3");
        @(negedge CLK);
        #2;
        Control_Branch_In = 2'b01;
        JumpAddr_In       = 11'h555;
        TrapClear_In      = 1'b0;
        #1 RESET_InLow = 1'b0;
        #1;
        push(11'h000, 1'b0, 1'b0, "async_reset_immediate");
        -> chk_ev;
        @(posedge CLK);
        push(11'h000, 1'b0, 1'b0, "reset_held_over_edge");
        #3 RESET_InLow = 1'b1;
        step(2'b01, 11'h555, 8'h00, 1'b0, 1'b0, 11'h000, 1'b1, 1'b0, "post_reset_init");
        step(2'b01, 11'h555, 8'h00, 1'b0, 1'b0, 11'h555, 1'b1, 1'b0, "post_reset_jump");

        repeat (2) @(negedge CLK);
        #1;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
